alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//   Shares one combinational 8-bit ALU instance between two requesters (port 0, port 1).
//   Round-robin arbitration, valid/ready request and response handshakes.
//   Registers the operands and the result around the ALU and counts completed operations.
//   Sits between the requester front-ends and the ALU; the ALU itself is instantiated outside.
// PARAMETERS
//   DATA_W   8   operand/result width; must equal ALU width
//   RR_INIT  0   port that holds round-robin priority after reset (0 or 1)
// PORTS
//   clk           in   1       clock, rising edge
//   rst_n         in   1       asynchronous reset, active-low
//   rN_valid      in   1       request N valid (N = 0,1)
//   rN_ready      out  1       request N accepted this cycle when rN_valid is also high
//   rN_op         in   3       request N opcode; ALU encoding, 000 add .. 111 equal
//   rN_x, rN_y    in   DATA_W  request N operands
//   rspN_valid    out  1       response valid to port N
//   rspN_ready    in   1       port N takes the response
//   rsp_result    out  DATA_W  response result, shared by both ports
//   rsp_overflow  out  1       response signed overflow, shared by both ports
//   alu_x, alu_y  out  DATA_W  ALU operands (registered)
//   alu_judge     out  3       ALU opcode (registered)
//   alu_result    in   DATA_W  ALU result (combinational from alu_*)
//   alu_overflow  in   1       ALU overflow flag
//   busy          out  1       high whenever the state is not IDLE
//   op_cnt        out  16      completed-operation count, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - state=IDLE; rr_ptr=RR_INIT; owner=0.
//     - All outputs 0: alu_x/alu_y/alu_judge, rsp_result, rsp_overflow, rspN_valid, op_cnt.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     - Only one rN_valid high: that port gets rN_ready=1, combinationally.
//     - Both high: the port equal to rr_ptr gets rN_ready=1. The other port gets 0.
//     - On accept: latch op/x/y into alu_judge/alu_x/alu_y; owner=N; rr_ptr = ~N; go to EXEC.
//     - No valid: stay in IDLE; rr_ptr unchanged.
//   EXEC (1 cycle):
//     - Capture rsp_result = alu_result.
//     - rsp_overflow = alu_overflow when alu_judge is 000 or 001; otherwise 0.
//     - Go to RESP.
//   RESP:
//     - rsp<owner>_valid=1; the other rspN_valid=0.
//     - rsp_result, rsp_overflow, alu_* held stable while rsp<owner>_ready=0.
//     - On rsp<owner>_ready=1: op_cnt += 1 (saturating); state -> IDLE.
//   rN_ready is 0 in EXEC and RESP. A request never stalls the response path.
//   Latency: accept in cycle T; rspN_valid high in cycle T+2.
//     - Back-to-back: the next accept is possible in the cycle after the response handshake.
//     - Minimum 3 cycles per operation.
//   alu_* keep their last values in IDLE (no toggle when nothing is accepted).
//   Requester rules: rN_valid with stable operands until rN_ready=1.
//     - Dropping rN_valid before acceptance is legal; no state change results.
//   Width: the result is taken from the ALU unmodified. Compare ops (110, 111) return 0 or 1 in bit 0.
//   Reset in EXEC or RESP: the operation is dropped with no response.
//     - op_cnt is cleared; rr_ptr returns to RR_INIT.
// TESTING
//   1. Reset, r0: op=000 x=8'h7F y=8'h01.
//      -> r0_ready at T, rsp0_valid at T+2, result 8'h80, overflow 1, op_cnt 1.
//   2. r0 and r1 valid in the same cycle, RR_INIT=0, each issuing 3 ops.
//      -> grants alternate 0,1,0,1,0,1; rsp1_valid is never high for a port-0 op.
//   3. r1: op=011 x=8'hF0 y=8'h3C, rsp1_ready held low 5 cycles.
//      -> result 8'h30 held stable, overflow 0.
//      -> r0_ready stays 0 until after the handshake.
//   4. r0: op=110 x=8'h05 y=8'h03 -> result 8'h01.
//      r0: op=111 x=y=8'hAA -> result 8'h01.
//      r0: op=010 x=8'h0F -> result 8'hF0, overflow 0.
//   5. rst_n pulsed low during RESP.
//      -> rsp0_valid and rsp1_valid drop to 0 immediately; busy 0; op_cnt 0; next request served normally.
//   6. Force op_cnt to 16'hFFFE, then complete 3 ops -> op_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one external combinational ALU between two requesters,
// with registered operands/results and a saturating completed-operation counter.
module alu_share_ctrl #(
    parameter int   DATA_W  = 8,
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [2:0]        r0_op,
    input  logic [DATA_W-1:0] r0_x,
    input  logic [DATA_W-1:0] r0_y,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [2:0]        r1_op,
    input  logic [DATA_W-1:0] r1_x,
    input  logic [DATA_W-1:0] r1_y,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_judge,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              busy,
    output logic [15:0]       op_cnt
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0] state;
    logic       rr_ptr;
    logic       owner;
    logic       idle;
    logic       rsp_take;

    // On contention the port named by rr_ptr wins; a lone requester always wins.
    assign idle       = state == IDLE;
    assign r0_ready   = idle & r0_valid & (~r1_valid | ~rr_ptr);
    assign r1_ready   = idle & r1_valid & (~r0_valid | rr_ptr);
    assign busy       = ~idle;
    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= RR_INIT;
            owner        <= 1'b0;
            alu_x        <= '0;
            alu_y        <= '0;
            alu_judge    <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            op_cnt       <= '0;
        end else if (state == IDLE) begin
            if (r0_ready | r1_ready) begin
                alu_judge <= r1_ready ? r1_op : r0_op;
                alu_x     <= r1_ready ? r1_x : r0_x;
                alu_y     <= r1_ready ? r1_y : r0_y;
                owner     <= r1_ready;
                rr_ptr    <= ~r1_ready;
                state     <= EXEC;
            end
        end else if (state == EXEC) begin
            // Overflow is only meaningful for add/sub.
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow & (alu_judge[2:1] == 2'b00);
            state        <= RESP;
        end else if (state == RESP) begin
            if (rsp_take) begin
                op_cnt <= op_cnt + {15'd0, ~&op_cnt};
                state  <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: transaction-level scoreboard for alu_share_ctrl with a behavioural ALU
// attached; directed scenarios followed by randomized two-port traffic.
module tb_alu_share_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [2:0] r0_op, r1_op, alu_judge;
    logic [7:0] r0_x, r0_y, r1_x, r1_y, rsp_result, alu_x, alu_y, alu_result;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, rsp_overflow, alu_overflow, busy;
    logic [15:0] op_cnt;
    logic [8:0] alu_out;

    int checks = 0;
    int failures = 0;
    int rr = 0;
    int cnt = 0;
    bit         pv[2];
    logic [2:0] po[2];
    logic [7:0] px[2];
    logic [7:0] py[2];

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(8), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_x(r0_x), .r0_y(r0_y),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_x(r1_x), .r1_y(r1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .alu_x(alu_x), .alu_y(alu_y), .alu_judge(alu_judge),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .busy(busy), .op_cnt(op_cnt)
    );

    // Returns {signed_overflow, result}; overflow is zero for every op but add/sub.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic v;
        r = '0;
        v = 1'b0;
        case (op)
            3'd0: begin r = x + y; v = (x[7] == y[7]) && (r[7] != x[7]); end
            3'd1: begin r = x - y; v = (x[7] != y[7]) && (r[7] != x[7]); end
            3'd2: r = ~x;
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = {7'd0, x > y};
            default: r = {7'd0, x == y};
        endcase
        return {v, r};
    endfunction

    // The external ALU raises junk overflow on logic/compare ops; the controller must mask it.
    assign alu_out      = alu_f(alu_judge, alu_x, alu_y);
    assign alu_result   = alu_out[7:0];
    assign alu_overflow = alu_out[8] | ((alu_judge > 3'd1) & alu_x[0]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        r0_valid = pv[0]; r0_op = po[0]; r0_x = px[0]; r0_y = py[0];
        r1_valid = pv[1]; r1_op = po[1]; r1_x = px[1]; r1_y = py[1];
    endtask

    task automatic new_req(input int p, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        pv[p] = 1'b1; po[p] = o; px[p] = x; py[p] = y;
    endtask

    // One full transaction starting in IDLE at posedge+1; `hold` cycles of response backpressure.
    task automatic run_op(input int hold);
        int g;
        logic [8:0] e;
        logic [7:0] xs;
        drive();
        #1;
        g = (pv[0] && pv[1]) ? rr : (pv[1] ? 1 : 0);
        chk("grant", {r1_ready, r0_ready}, (g == 1) ? 2 : 1);
        e = alu_f(po[g], px[g], py[g]);
        xs = px[g];
        @(posedge clk); #1;
        pv[g] = 1'b0;
        drive();
        #1;
        chk("exec_state", {busy, r1_ready, r0_ready, rsp1_valid, rsp0_valid}, 5'b10000);
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", {rsp1_valid, rsp0_valid}, (g == 1) ? 2 : 1);
            chk("rsp_result", rsp_result, e[7:0]);
            chk("rsp_overflow", rsp_overflow, e[8]);
            chk("resp_no_ready", {r1_ready, r0_ready}, 0);
            rsp0_ready = (g == 0) ? (i == hold) : 1'($urandom_range(1));
            rsp1_ready = (g == 1) ? (i == hold) : 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        cnt = (cnt == 65535) ? cnt : cnt + 1;
        rr = 1 - g;
        chk("idle_busy", busy, 0);
        chk("op_cnt", op_cnt, cnt);
        chk("alu_hold", alu_x, xs);
    endtask

    initial begin
        pv[0] = 0; pv[1] = 0;
        po[0] = 0; po[1] = 0; px[0] = 0; px[1] = 0; py[0] = 0; py[1] = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        drive();
        #12;
        chk("reset_outs", {alu_x, alu_y, alu_judge, rsp_result, rsp_overflow, rsp0_valid, rsp1_valid, busy}, 0);
        chk("reset_cnt", op_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // Signed add overflow 7F+01.
        new_req(0, 3'b000, 8'h7F, 8'h01);
        run_op(0);
        // Contention: three ops per port, grants must alternate.
        for (int k = 0; k < 6; k++) begin
            if (!pv[0]) new_req(0, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            if (!pv[1]) new_req(1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            run_op(k % 2);
        end
        pv[0] = 0;
        // Port 1 AND with backpressure while port 0 waits.
        new_req(1, 3'b011, 8'hF0, 8'h3C);
        run_op(0);
        new_req(1, 3'b011, 8'hF0, 8'h3C);
        drive();
        new_req(0, 3'b001, 8'h80, 8'h01);
        pv[0] = 0;
        run_op(5);
        new_req(0, 3'b001, 8'h80, 8'h01);
        run_op(1);
        new_req(0, 3'b110, 8'h05, 8'h03); run_op(0);
        new_req(0, 3'b111, 8'hAA, 8'hAA); run_op(0);
        new_req(0, 3'b010, 8'h0F, 8'h55); run_op(0);
        // Reset during RESP drops the op and restores priority to port 0.
        new_req(0, 3'b100, 8'h11, 8'h22);
        drive();
        @(posedge clk); #1;
        pv[0] = 0;
        drive();
        @(posedge clk); #1;
        chk("pre_reset_rsp", rsp0_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp", {rsp1_valid, rsp0_valid, busy}, 0);
        chk("mid_reset_cnt", op_cnt, 0);
        chk("mid_reset_alu", alu_x, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rr = 0;
        cnt = 0;
        new_req(0, 3'b101, 8'h3C, 8'h0F);
        new_req(1, 3'b000, 8'h01, 8'h02);
        run_op(0);
        run_op(0);
        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(1) == 1)
                    new_req(p, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            if (!pv[0] && !pv[1])
                new_req(int'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            run_op(int'($urandom_range(3)));
        end
        // Counter saturation.
        pv[0] = 0; pv[1] = 0;
        drive();
        force dut.op_cnt = 16'hFFFE;
        #1;
        release dut.op_cnt;
        cnt = 65534;
        for (int k = 0; k < 3; k++) begin
            new_req(k % 2, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            run_op(0);
        end
        chk("sat_cnt", op_cnt, 16'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
